washing_machine_ctrl: RTL and testbench
=======================================

// Module: washing_machine_ctrl
// PURPOSE
//  Parametrised successor of the single-cycle washer top: one block holding the
//  programme FSM and a pausable phase timer. Adds multi-rinse loops, per-mode
//  duration scaling, pause with timer hold, door interlock and agitation reversal.
//  Sits between the front-panel/door inputs and the valve/motor drivers.
// PARAMETERS
//  TIMER_W    32  width of phase down-counter (all durations must fit, >=1)
//  FILL_T     20  cycles per FILL phase
//  WASH_T     60  cycles per WASH phase (normal mode)
//  RINSE_T    30  cycles per RINSE phase
//  DRAIN_T    15  cycles per DRAIN phase
//  SPIN_T     40  cycles per SPIN phase
//  NUM_RINSE  2   rinse loops in normal mode (1..7)
//  DIR_PERIOD 10  agitation cycles between motor direction reversals (>=1)
// PORTS
//  clk          in  1  clock, rising edge
//  reset        in  1  asynchronous reset, active-low
//  start_pause  in  1  panel button; its rising edge is the command
//  mode_select  in  2  00 quick, 01 normal, 10 heavy, 11 spin-only; latched at start
//  door_sensor  in  1  1 = door open
//  water_valve  out 1  inlet valve on
//  drain_valve  out 1  drain valve on
//  motor        out 1  motor on
//  motor_dir    out 2  01 fwd, 10 rev, 00 off
//  door_lock    out 1  door latch engaged
//  leds         out 4  {done, paused, running, door_lock}
// BEHAVIOUR
//  - reset low: state IDLE, timer 0, all outputs 0, paused 0, edge register 0.
//  - All outputs registered (decoded from next state); change on the same edge as state.
//  - btn = start_pause & ~start_pause_q (start_pause_q reset to 0).
//  - States: IDLE, FILL, WASH, DRAIN, RINSE, SPIN, DONE; paused is a separate flag.
//  - IDLE: btn & door closed -> latch mode, rinse_cnt = rinses(mode), go FILL
//    (spin-only -> DRAIN). btn with door open is ignored.
//  - Phase entry loads timer = duration-1; each unpaused cycle decrements; phase
//    ends on the cycle timer==0, so each phase lasts exactly duration cycles.
//  - Sequence: FILL->WASH->DRAIN; then if rinse_cnt>0: FILL->RINSE->DRAIN with
//    rinse_cnt-1, repeated; when rinse_cnt==0 after DRAIN -> SPIN -> DONE.
//    FILL exit goes to WASH on first fill, RINSE afterwards (wash_done flag).
//  - Mode table: quick WASH_T>>1, 1 rinse; normal WASH_T, NUM_RINSE;
//    heavy WASH_T<<1, NUM_RINSE+1; spin-only DRAIN then SPIN, no rinse.
//    Quick WASH_T>>1 of 0 is treated as 1.
//  - Outputs: FILL water_valve; DRAIN drain_valve; WASH/RINSE motor with dir
//    toggling 01<->10 every DIR_PERIOD running cycles (starts 01 at phase entry);
//    SPIN motor + drain_valve, dir 01. door_lock=1 in every state but IDLE/DONE.
//  - Pause: btn in FILL..SPIN toggles paused. Door open in FILL..SPIN forces
//    paused=1; while door open, btn cannot clear paused. While paused: timer and
//    dir counter hold, water_valve/drain_valve/motor = 0, motor_dir = 00.
//    Resume restores the phase outputs from the held counters.
//  - Door open and btn on the same cycle: paused=1 (door wins).
//  - DONE: leds[3]=1, all actuators 0; btn -> IDLE. Door opening in DONE is allowed.
//  - leds[1] running = state in FILL..SPIN and not paused.
//  - Reset low mid-run: immediate return to IDLE, all outputs 0, no resume memory.
// TESTING  (FILL_T=4 WASH_T=8 RINSE_T=4 DRAIN_T=3 SPIN_T=5 NUM_RINSE=1 DIR_PERIOD=2)
//  1 normal, door closed, btn pulse -> water_valve 4 cyc, motor 8 cyc with dir
//    01,01,10,10,...; drain 3, fill 4, rinse 4, drain 3, spin 5; leds[3] at cycle 31.
//  2 quick mode -> WASH lasts 4 cycles, 1 rinse, DONE at cycle 27; heavy -> WASH 16,
//    2 rinses, DONE at cycle 50; spin-only -> DRAIN 3 then SPIN 5, DONE at cycle 8.
//  3 btn at WASH cycle 3, hold 10 cycles, btn -> motor 0 and leds[2]=1 while held,
//    WASH resumes with 5 cycles left, total run extended by exactly 10 cycles.
//  4 door opens mid-RINSE -> paused next edge, btn ignored until closed; close then
//    btn -> resumes with the held timer value; door open in IDLE + btn -> stays IDLE.
//  5 reset asserted low during SPIN -> all outputs 0 asynchronously, state IDLE;
//    release and btn -> fresh cycle from FILL using the newly latched mode.
//  6 start_pause held high 20 cycles -> counts as one btn only; DONE + btn -> IDLE.

Source files
------------

// File: rtl/washing_machine_ctrl.sv
// Washer programme FSM with a pausable phase down-counter, rinse loop, door interlock and agitation reversal.
// Outputs are registered and decoded from next state, so they change on the same edge as the state.
module washing_machine_ctrl #(
  parameter int TIMER_W    = 32,
  parameter int FILL_T     = 20,
  parameter int WASH_T     = 60,
  parameter int RINSE_T    = 30,
  parameter int DRAIN_T    = 15,
  parameter int SPIN_T     = 40,
  parameter int NUM_RINSE  = 2,
  parameter int DIR_PERIOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_pause,
  input  logic [1:0] mode_select,
  input  logic       door_sensor,
  output logic       water_valve,
  output logic       drain_valve,
  output logic       motor,
  output logic [1:0] motor_dir,
  output logic       door_lock,
  output logic [3:0] leds
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WASH,
    ST_DRAIN,
    ST_RINSE,
    ST_SPIN,
    ST_DONE
  } state_e;

  localparam logic [1:0] MODE_QUICK  = 2'b00;
  localparam logic [1:0] MODE_NORMAL = 2'b01;
  localparam logic [1:0] MODE_HEAVY  = 2'b10;
  localparam logic [1:0] MODE_SPIN   = 2'b11;

  localparam logic [1:0] DIR_OFF = 2'b00;
  localparam logic [1:0] DIR_FWD = 2'b01;
  localparam logic [1:0] DIR_REV = 2'b10;

  // Halving a very short wash must still leave at least one cycle of agitation.
  localparam int WASH_QUICK_T = ((WASH_T >> 1) == 0) ? 1 : (WASH_T >> 1);
  localparam int WASH_HEAVY_T = WASH_T << 1;

  localparam int               DIR_W    = (DIR_PERIOD > 1) ? $clog2(DIR_PERIOD) : 1;
  localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(DIR_PERIOD - 1);

  // Timer reload value on entry to a phase; wash length depends on the latched mode.
  function automatic logic [TIMER_W-1:0] phase_load(input state_e s, input logic [1:0] m);
    logic [TIMER_W-1:0] ld;
    ld = '0;
    case (s)
      ST_FILL:  ld = TIMER_W'(FILL_T - 1);
      ST_WASH: begin
        case (m)
          MODE_QUICK: ld = TIMER_W'(WASH_QUICK_T - 1);
          MODE_HEAVY: ld = TIMER_W'(WASH_HEAVY_T - 1);
          default:    ld = TIMER_W'(WASH_T - 1);
        endcase
      end
      ST_RINSE: ld = TIMER_W'(RINSE_T - 1);
      ST_DRAIN: ld = TIMER_W'(DRAIN_T - 1);
      ST_SPIN:  ld = TIMER_W'(SPIN_T - 1);
      default:  ld = '0;
    endcase
    return ld;
  endfunction

  function automatic logic [3:0] rinses(input logic [1:0] m);
    logic [3:0] n;
    case (m)
      MODE_QUICK:  n = 4'd1;
      MODE_NORMAL: n = 4'(NUM_RINSE);
      MODE_HEAVY:  n = 4'(NUM_RINSE + 1);
      default:     n = 4'd0;
    endcase
    return n;
  endfunction

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               paused_q, paused_d;
  logic               start_pause_q, start_pause_d;
  logic [1:0]         mode_q, mode_d;
  logic [3:0]         rinse_cnt_q, rinse_cnt_d;
  logic               wash_done_q, wash_done_d;
  logic [DIR_W-1:0]   dir_cnt_q, dir_cnt_d;
  logic               dir_rev_q, dir_rev_d;

  logic               water_valve_q, water_valve_d;
  logic               drain_valve_q, drain_valve_d;
  logic               motor_q, motor_d;
  logic [1:0]         motor_dir_q, motor_dir_d;
  logic               door_lock_q, door_lock_d;
  logic [3:0]         leds_q, leds_d;

  logic               btn;
  logic               in_phase_d;
  logic               run_d;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    paused_d      = paused_q;
    mode_d        = mode_q;
    rinse_cnt_d   = rinse_cnt_q;
    wash_done_d   = wash_done_q;
    dir_cnt_d     = dir_cnt_q;
    dir_rev_d     = dir_rev_q;
    start_pause_d = start_pause;
    btn           = start_pause & ~start_pause_q;

    case (state_q)
      ST_IDLE: begin
        paused_d = 1'b0;
        if (btn && !door_sensor) begin
          mode_d      = mode_select;
          rinse_cnt_d = rinses(mode_select);
          wash_done_d = 1'b0;
          state_d     = (mode_select == MODE_SPIN) ? ST_DRAIN : ST_FILL;
        end
      end
      ST_DONE: begin
        paused_d = 1'b0;
        if (btn) state_d = ST_IDLE;
      end
      default: begin
        // An open door always wins over the button, so it can never be used to resume.
        if (door_sensor) paused_d = 1'b1;
        else if (btn)    paused_d = ~paused_q;

        // Counters advance only on edges after which the machine is running,
        // which keeps each phase at exactly its duration of active cycles.
        if (!paused_d) begin
          if (timer_q == '0) begin
            case (state_q)
              ST_FILL: begin
                state_d     = wash_done_q ? ST_RINSE : ST_WASH;
                wash_done_d = 1'b1;
              end
              ST_WASH, ST_RINSE: state_d = ST_DRAIN;
              ST_DRAIN: begin
                if (rinse_cnt_q != 4'd0) begin
                  state_d     = ST_FILL;
                  rinse_cnt_d = rinse_cnt_q - 4'd1;
                end else begin
                  state_d = ST_SPIN;
                end
              end
              default: state_d = ST_DONE;
            endcase
          end else begin
            timer_d = timer_q - TIMER_W'(1);
            if (state_q == ST_WASH || state_q == ST_RINSE) begin
              if (dir_cnt_q == DIR_LAST) begin
                dir_cnt_d = '0;
                dir_rev_d = ~dir_rev_q;
              end else begin
                dir_cnt_d = dir_cnt_q + DIR_W'(1);
              end
            end
          end
        end
      end
    endcase

    if (state_d != state_q) begin
      timer_d   = phase_load(state_d, mode_d);
      dir_cnt_d = '0;
      dir_rev_d = 1'b0;
    end

    in_phase_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    run_d         = in_phase_d && !paused_d;
    water_valve_d = run_d && (state_d == ST_FILL);
    drain_valve_d = run_d && (state_d == ST_DRAIN || state_d == ST_SPIN);
    motor_d       = run_d && (state_d == ST_WASH || state_d == ST_RINSE || state_d == ST_SPIN);
    motor_dir_d   = DIR_OFF;
    if (motor_d) begin
      if (state_d == ST_SPIN) motor_dir_d = DIR_FWD;
      else                    motor_dir_d = dir_rev_d ? DIR_REV : DIR_FWD;
    end
    door_lock_d = in_phase_d;
    leds_d      = {state_d == ST_DONE, paused_d, run_d, door_lock_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      paused_q      <= 1'b0;
      start_pause_q <= 1'b0;
      mode_q        <= MODE_QUICK;
      rinse_cnt_q   <= 4'd0;
      wash_done_q   <= 1'b0;
      dir_cnt_q     <= '0;
      dir_rev_q     <= 1'b0;
      water_valve_q <= 1'b0;
      drain_valve_q <= 1'b0;
      motor_q       <= 1'b0;
      motor_dir_q   <= DIR_OFF;
      door_lock_q   <= 1'b0;
      leds_q        <= 4'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      paused_q      <= paused_d;
      start_pause_q <= start_pause_d;
      mode_q        <= mode_d;
      rinse_cnt_q   <= rinse_cnt_d;
      wash_done_q   <= wash_done_d;
      dir_cnt_q     <= dir_cnt_d;
      dir_rev_q     <= dir_rev_d;
      water_valve_q <= water_valve_d;
      drain_valve_q <= drain_valve_d;
      motor_q       <= motor_d;
      motor_dir_q   <= motor_dir_d;
      door_lock_q   <= door_lock_d;
      leds_q        <= leds_d;
    end
  end

  assign water_valve = water_valve_q;
  assign drain_valve = drain_valve_q;
  assign motor       = motor_q;
  assign motor_dir   = motor_dir_q;
  assign door_lock   = door_lock_q;
  assign leds        = leds_q;

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Directed bench for washing_machine_ctrl: per-cycle output traces against hand-built phase tables.
module tb_washing_machine_ctrl;

  localparam int FILL_T    = 4;
  localparam int WASH_T    = 8;
  localparam int RINSE_T   = 4;
  localparam int DRAIN_T   = 3;
  localparam int SPIN_T    = 5;
  localparam int NUM_RINSE = 1;
  localparam int DIR_P     = 2;

  localparam int P_IDLE  = 0;
  localparam int P_FILL  = 1;
  localparam int P_WASH  = 2;
  localparam int P_DRAIN = 3;
  localparam int P_RINSE = 4;
  localparam int P_SPIN  = 5;
  localparam int P_DONE  = 6;
  localparam int P_PAUSE = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_pause = 1'b0;
  logic [1:0] mode_select = 2'b01;
  logic       door_sensor = 1'b0;
  logic       water_valve;
  logic       drain_valve;
  logic       motor;
  logic [1:0] motor_dir;
  logic       door_lock;
  logic [3:0] leds;
  logic [9:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_q[$];
  logic       btn_at[0:127];
  logic       door_at[0:127];

  washing_machine_ctrl #(
    .TIMER_W(32), .FILL_T(FILL_T), .WASH_T(WASH_T), .RINSE_T(RINSE_T),
    .DRAIN_T(DRAIN_T), .SPIN_T(SPIN_T), .NUM_RINSE(NUM_RINSE), .DIR_PERIOD(DIR_P)
  ) dut (
    .clk(clk), .reset(reset), .start_pause(start_pause), .mode_select(mode_select),
    .door_sensor(door_sensor), .water_valve(water_valve), .drain_valve(drain_valve),
    .motor(motor), .motor_dir(motor_dir), .door_lock(door_lock), .leds(leds)
  );

  always #5 clk = ~clk;

  assign outs = {water_valve, drain_valve, motor, motor_dir, door_lock, leds};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // {water, drain, motor, dir[1:0], lock, leds[3:0]} for cycle k of a phase
  function automatic logic [9:0] exp_out(input int ph, input int k);
    case (ph)
      P_FILL:           return 10'b100_00_1_0011;
      P_WASH, P_RINSE:  return {3'b001, (((k / DIR_P) % 2) != 0) ? 2'b10 : 2'b01, 5'b1_0011};
      P_DRAIN:          return 10'b010_00_1_0011;
      P_SPIN:           return 10'b011_01_1_0011;
      P_DONE:           return 10'b000_00_0_1000;
      P_PAUSE:          return 10'b000_00_1_0101;
      default:          return 10'b000_00_0_0000;
    endcase
  endfunction

  task automatic add(input int ph, input int k0, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back(exp_out(ph, k0 + j));
  endtask

  task automatic add_prog(input int wash_len, input int nrinse, input bit spin_only);
    if (!spin_only) begin
      add(P_FILL, 0, FILL_T);
      add(P_WASH, 0, wash_len);
    end
    add(P_DRAIN, 0, DRAIN_T);
    for (int r = 0; r < nrinse; r++) begin
      add(P_FILL, 0, FILL_T);
      add(P_RINSE, 0, RINSE_T);
      add(P_DRAIN, 0, DRAIN_T);
    end
    add(P_SPIN, 0, SPIN_T);
    add(P_DONE, 0, 1);
  endtask

  task automatic clear_sched();
    exp_q.delete();
    for (int j = 0; j < 128; j++) begin
      btn_at[j]  = 1'b0;
      door_at[j] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    start_pause = 1'b0;
    door_sensor = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_outs", {22'd0, outs}, 32'd0);
  endtask

  // Sample index i is taken after edge i; inputs for edge i+1 are driven right after it.
  task automatic run_trace(input string tag);
    start_pause = btn_at[0];
    door_sensor = door_at[0];
    @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), {22'd0, outs}, {22'd0, exp_q[i]});
      start_pause = btn_at[i + 1];
      door_sensor = door_at[i + 1];
      @(negedge clk);
    end
    start_pause = 1'b0;
    door_sensor = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: normal programme, DONE at cycle 31
    do_reset();
    clear_sched();
    mode_select = 2'b01;
    btn_at[0] = 1'b1;
    add_prog(WASH_T, NUM_RINSE, 1'b0);
    run_trace("normal");

    // 2: quick, heavy, spin-only
    do_reset();
    clear_sched();
    mode_select = 2'b00;
    btn_at[0] = 1'b1;
    add_prog(WASH_T >> 1, 1, 1'b0);
    run_trace("quick");

    do_reset();
    clear_sched();
    mode_select = 2'b10;
    btn_at[0] = 1'b1;
    add_prog(WASH_T << 1, NUM_RINSE + 1, 1'b0);
    run_trace("heavy");

    do_reset();
    clear_sched();
    mode_select = 2'b11;
    btn_at[0] = 1'b1;
    add_prog(0, 0, 1'b1);
    run_trace("spinonly");

    // 3: pause at WASH cycle 3 for 10 cycles, DONE at cycle 41
    do_reset();
    clear_sched();
    mode_select = 2'b01;
    btn_at[0]  = 1'b1;
    btn_at[7]  = 1'b1;
    btn_at[17] = 1'b1;
    add(P_FILL, 0, FILL_T);
    add(P_WASH, 0, 3);
    add(P_PAUSE, 0, 10);
    add(P_WASH, 3, 5);
    add(P_DRAIN, 0, DRAIN_T);
    add(P_FILL, 0, FILL_T);
    add(P_RINSE, 0, RINSE_T);
    add(P_DRAIN, 0, DRAIN_T);
    add(P_SPIN, 0, SPIN_T);
    add(P_DONE, 0, 1);
    run_trace("pause");

    // 4: door opens in RINSE, button ignored while open; then door open in IDLE
    do_reset();
    clear_sched();
    mode_select = 2'b01;
    btn_at[0]  = 1'b1;
    btn_at[23] = 1'b1;
    btn_at[28] = 1'b1;
    btn_at[40] = 1'b1;
    btn_at[43] = 1'b1;
    for (int j = 20; j <= 25; j++) door_at[j] = 1'b1;
    for (int j = 42; j <= 44; j++) door_at[j] = 1'b1;
    add(P_FILL, 0, FILL_T);
    add(P_WASH, 0, WASH_T);
    add(P_DRAIN, 0, DRAIN_T);
    add(P_FILL, 0, FILL_T);
    add(P_RINSE, 0, 1);
    add(P_PAUSE, 0, 8);
    add(P_RINSE, 1, 3);
    add(P_DRAIN, 0, DRAIN_T);
    add(P_SPIN, 0, SPIN_T);
    add(P_DONE, 0, 1);
    add(P_IDLE, 0, 6);
    run_trace("door");

    // 5: asynchronous reset during SPIN, then a fresh quick programme
    do_reset();
    clear_sched();
    mode_select = 2'b01;
    btn_at[0] = 1'b1;
    add(P_FILL, 0, FILL_T);
    add(P_WASH, 0, WASH_T);
    add(P_DRAIN, 0, DRAIN_T);
    add(P_FILL, 0, FILL_T);
    add(P_RINSE, 0, RINSE_T);
    add(P_DRAIN, 0, DRAIN_T);
    add(P_SPIN, 0, 2);
    run_trace("pre_rst");
    check("spin_before_rst", {22'd0, outs}, {22'd0, exp_out(P_SPIN, 0)});
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_outs", {22'd0, outs}, 32'd0);
    @(negedge clk);
    mode_select = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    clear_sched();
    btn_at[0] = 1'b1;
    add_prog(WASH_T >> 1, 1, 1'b0);
    run_trace("after_rst");

    // 6: button held 20 cycles is a single press; DONE + btn returns to IDLE
    do_reset();
    clear_sched();
    mode_select = 2'b01;
    for (int j = 0; j < 20; j++) btn_at[j] = 1'b1;
    btn_at[32] = 1'b1;
    add_prog(WASH_T, NUM_RINSE, 1'b0);
    add(P_IDLE, 0, 2);
    run_trace("held");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
